// File: rtl/ch0re_pkg.sv
// Shared types and constants for the ch0re memory arbitration path.
package ch0re_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} mem_owner_t;

  localparam logic [7:0] MEM_BE_NONE = 8'h00;
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/ch0re_starve_ctr.sv
// Saturating fetch-starvation counter: clear dominates, increment stops at the limit.
module ch0re_starve_ctr
  import ch0re_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ch0re_mem_arbiter.sv
// Arbitrates one single-port 64-bit array between instruction fetch and the
// load/store unit; data wins unless fetch has been starved for STARVE_LIMIT cycles.
module ch0re_mem_arbiter
  import ch0re_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 11,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_req_valid,
  output logic                      if_req_ready,
  input  logic [63:0]               if_req_addr,
  input  logic                      if_flush,
  output logic                      if_rsp_valid,
  output logic [31:0]               if_rsp_instr,
  output logic                      if_rsp_err,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [63:0]               d_req_addr,
  input  logic [7:0]                d_req_be,
  input  logic [63:0]               d_req_wdata,
  output logic                      d_rsp_valid,
  output logic [63:0]               d_rsp_rdata,
  output logic                      d_rsp_err,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wen,
  output logic [63:0]               mem_wdata,
  input  logic [63:0]               mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic                if_err;
  logic                d_err;
  logic                if_live;
  logic                force_if;
  logic                gnt_if;
  logic                gnt_d;
  logic [STARVE_W-1:0] starve_cnt;
  logic [2:0]          d_addr_lsb_unused;

  mem_owner_t owner_p1;
  logic       err_p1;
  logic       be_nz_p1;
  logic       hi_p1;

  assign if_err = (|if_req_addr[63:3+MEM_ADDR_WIDTH]) | (|if_req_addr[1:0]);
  assign d_err  = |d_req_addr[63:3+MEM_ADDR_WIDTH];
  assign d_addr_lsb_unused = d_req_addr[2:0];

  // A flushed fetch is invisible to arbitration for that cycle.
  assign if_live  = if_req_valid & ~if_flush;
  assign force_if = if_live & (starve_cnt == LIMIT);

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (rst_n) begin
      if (force_if) begin
        gnt_if = 1'b1;
      end else if (d_req_valid) begin
        gnt_d = 1'b1;
      end else if (if_live) begin
        gnt_if = 1'b1;
      end
    end
  end

  assign if_req_ready = gnt_if;
  assign d_req_ready  = gnt_d;

  ch0re_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (if_live & gnt_d),
    .clr  (gnt_if | ~if_req_valid),
    .cnt  (starve_cnt)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wen   = MEM_BE_NONE;
    mem_wdata = '0;
    if (gnt_d) begin
      mem_addr  = d_req_addr[3 +: MEM_ADDR_WIDTH];
      mem_wen   = d_err ? MEM_BE_NONE : d_req_be;
      mem_wdata = d_req_wdata;
    end else if (gnt_if) begin
      mem_addr = if_req_addr[3 +: MEM_ADDR_WIDTH];
    end
  end

  // Stage p0 -> p1: remember who owns the array read returning next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_p1 <= OWN_NONE;
    end else if (gnt_d) begin
      owner_p1 <= OWN_D;
    end else if (gnt_if) begin
      owner_p1 <= OWN_IF;
    end else begin
      owner_p1 <= OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    err_p1   <= gnt_d ? d_err : if_err;
    be_nz_p1 <= gnt_d & (d_req_be != MEM_BE_NONE);
    hi_p1    <= if_req_addr[2];
  end

  // Stage p1: steer array data to the owner; reset discards anything outstanding.
  always_comb begin
    if_rsp_valid = rst_n & (owner_p1 == OWN_IF) & ~if_flush;
    d_rsp_valid  = rst_n & (owner_p1 == OWN_D);
    if_rsp_err   = if_rsp_valid & err_p1;
    d_rsp_err    = d_rsp_valid & err_p1;
    if_rsp_instr = '0;
    d_rsp_rdata  = '0;
    if (if_rsp_valid && !err_p1) begin
      if_rsp_instr = hi_p1 ? mem_rdata[63:32] : mem_rdata[31:0];
    end
    if (d_rsp_valid && !err_p1 && !be_nz_p1) begin
      d_rsp_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_ch0re_mem_arbiter.sv
// Directed bench for ch0re_mem_arbiter with a behavioural synchronous single-port array.
module tb_ch0re_mem_arbiter;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid;
  logic          if_req_ready;
  logic [63:0]   if_req_addr;
  logic          if_flush;
  logic          if_rsp_valid;
  logic [31:0]   if_rsp_instr;
  logic          if_rsp_err;
  logic          d_req_valid;
  logic          d_req_ready;
  logic [63:0]   d_req_addr;
  logic [7:0]    d_req_be;
  logic [63:0]   d_req_wdata;
  logic          d_rsp_valid;
  logic [63:0]   d_rsp_rdata;
  logic          d_rsp_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wen;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  logic [63:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ch0re_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
    .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    for (int b = 0; b < 8; b++) begin
      if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_be = '0; d_req_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[0] = 64'h12345678_9ABCDEF0;
    mem[2] = 64'hAABBCCDD_11223344;
    idle();
    rst_n = 1'b0;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    chk("rst_if_ready", 64'(if_req_ready), 64'd0);
    chk("rst_d_ready", 64'(d_req_ready), 64'd0);
    step(); step();
    chk("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    chk("rst_d_rsp_valid", 64'(d_rsp_valid), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    idle();
    rst_n = 1'b1;
    step();

    // IF only, both halves of mem[2]
    if_req_valid = 1'b1; if_req_addr = 64'h10; #1;
    chk("t1_ready0", 64'(if_req_ready), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'd2);
    chk("t1_mem_wen", 64'(mem_wen), 64'd0);
    step();
    if_req_addr = 64'h14; #1;
    chk("t1_ready1", 64'(if_req_ready), 64'd1);
    chk("t1_rsp_valid0", 64'(if_rsp_valid), 64'd1);
    chk("t1_instr0", 64'(if_rsp_instr), 64'h11223344);
    chk("t1_err0", 64'(if_rsp_err), 64'd0);
    step();
    idle(); #1;
    chk("t1_rsp_valid1", 64'(if_rsp_valid), 64'd1);
    chk("t1_instr1", 64'(if_rsp_instr), 64'hAABBCCDD);
    chk("t1_d_rsp_quiet", 64'(d_rsp_valid), 64'd0);
    step();

    // store low word then load it back
    d_req_valid = 1'b1; d_req_addr = 64'h40; d_req_be = 8'h0F;
    d_req_wdata = 64'hFFFFFFFF_DEADBEEF; #1;
    chk("t2_st_ready", 64'(d_req_ready), 64'd1);
    chk("t2_st_wen", 64'(mem_wen), 64'h0F);
    chk("t2_st_addr", 64'(mem_addr), 64'd8);
    chk("t2_st_wdata", mem_wdata, 64'hFFFFFFFF_DEADBEEF);
    step();
    d_req_be = 8'h00; d_req_wdata = '0; #1;
    chk("t2_ld_wen", 64'(mem_wen), 64'd0);
    chk("t2_st_ack", 64'(d_rsp_valid), 64'd1);
    chk("t2_st_rdata", d_rsp_rdata, 64'd0);
    step();
    idle(); #1;
    chk("t2_ld_valid", 64'(d_rsp_valid), 64'd1);
    chk("t2_ld_rdata", d_rsp_rdata, 64'h00000000_DEADBEEF);
    chk("t2_ld_err", 64'(d_rsp_err), 64'd0);
    chk("t2_if_quiet", 64'(if_rsp_valid), 64'd0);
    step();

    // contention: D wins 0-3, fetch forced at 4, D again 5-7
    for (int i = 0; i < 8; i++) begin
      if_req_valid = 1'b1; if_req_addr = 64'h10;
      d_req_valid = 1'b1; d_req_addr = 64'h40; d_req_be = 8'h00; #1;
      chk($sformatf("t3_if_ready%0d", i), 64'(if_req_ready), 64'(i == 4));
      chk($sformatf("t3_d_ready%0d", i), 64'(d_req_ready), 64'(i != 4));
      if (i > 0) begin
        chk($sformatf("t3_if_rsp%0d", i), 64'(if_rsp_valid), 64'(i == 5));
        chk($sformatf("t3_d_rsp%0d", i), 64'(d_rsp_valid), 64'(i != 5));
      end
      if (i == 4) chk("t3_cnt_at_limit", 64'(dut.starve_cnt), 64'd4);
      if (i == 5) chk("t3_cnt_cleared", 64'(dut.starve_cnt), 64'd0);
      step();
    end
    idle(); step();

    // flush kills the fetch granted the cycle before
    if_req_valid = 1'b1; if_req_addr = 64'h0; #1;
    chk("t4_if_grant", 64'(if_req_ready), 64'd1);
    step();
    if_flush = 1'b1; d_req_valid = 1'b1; d_req_addr = 64'h40; d_req_be = 8'h00; #1;
    chk("t4_flush_if_ready", 64'(if_req_ready), 64'd0);
    chk("t4_flush_d_ready", 64'(d_req_ready), 64'd1);
    chk("t4_flush_rsp", 64'(if_rsp_valid), 64'd0);
    step();
    idle(); #1;
    chk("t4_d_rsp", 64'(d_rsp_valid), 64'd1);
    chk("t4_d_rdata", d_rsp_rdata, 64'h00000000_DEADBEEF);
    chk("t4_no_if_rsp", 64'(if_rsp_valid), 64'd0);
    step();

    // error requests
    if_req_valid = 1'b1; if_req_addr = 64'h6; #1;
    chk("t5_if_err_ready", 64'(if_req_ready), 64'd1);
    chk("t5_if_err_wen", 64'(mem_wen), 64'd0);
    step();
    idle();
    d_req_valid = 1'b1; d_req_addr = 64'h1_0000_0000; d_req_be = 8'hFF;
    d_req_wdata = 64'hCAFEF00D_CAFEF00D; #1;
    chk("t5_if_err_valid", 64'(if_rsp_valid), 64'd1);
    chk("t5_if_err_flag", 64'(if_rsp_err), 64'd1);
    chk("t5_if_err_instr", 64'(if_rsp_instr), 64'd0);
    chk("t5_st_err_ready", 64'(d_req_ready), 64'd1);
    chk("t5_st_err_wen", 64'(mem_wen), 64'd0);
    step();
    d_req_be = 8'h00; d_req_wdata = '0; #1;
    chk("t5_ld_err_wen", 64'(mem_wen), 64'd0);
    chk("t5_st_err_flag", 64'(d_rsp_err), 64'd1);
    step();
    idle(); #1;
    chk("t5_ld_err_valid", 64'(d_rsp_valid), 64'd1);
    chk("t5_ld_err_flag", 64'(d_rsp_err), 64'd1);
    chk("t5_ld_err_rdata", d_rsp_rdata, 64'd0);
    step();
    d_req_valid = 1'b1; d_req_addr = 64'h0; #1;
    step();
    idle(); #1;
    chk("t5_mem0_intact", d_rsp_rdata, 64'h12345678_9ABCDEF0);
    step();

    // reset in the cycle after a load grant discards its response
    d_req_valid = 1'b1; d_req_addr = 64'h40; d_req_be = 8'h00; #1;
    chk("t6_ld_grant", 64'(d_req_ready), 64'd1);
    step();
    rst_n = 1'b0; if_req_valid = 1'b1; if_req_addr = 64'h10; #1;
    chk("t6_rst_d_rsp", 64'(d_rsp_valid), 64'd0);
    chk("t6_rst_d_rdata", d_rsp_rdata, 64'd0);
    chk("t6_rst_if_ready", 64'(if_req_ready), 64'd0);
    chk("t6_rst_d_ready", 64'(d_req_ready), 64'd0);
    step();
    rst_n = 1'b1; #1;
    chk("t6_rel_d_rsp", 64'(d_rsp_valid), 64'd0);
    chk("t6_rel_if_rsp", 64'(if_rsp_valid), 64'd0);
    chk("t6_rel_d_ready", 64'(d_req_ready), 64'd1);
    step();
    idle(); #1;
    chk("t6_resume_valid", 64'(d_rsp_valid), 64'd1);
    chk("t6_resume_rdata", d_rsp_rdata, 64'h00000000_DEADBEEF);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
